shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 143 ++++++++++++++
 tb/tb_shift_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - sequential one-bit-per-cycle shifter/rotator with valid/ready handshake
//
// Purpose:
//   Accepts an N-bit operand with a shift distance and direction, then shifts
//   the operand one bit per clock until the distance is used up, and holds the
//   result until the consumer takes it.
//
// Configuration macro:
//   SHIFT_SEQ_ROT_EN - when defined, in_rot=1 turns each step into a rotate.
//                      When undefined, in_rot is latched but ignored and all
//                      shifts are logical (zero fill).
//
// Ports:
//   clk       in   clock, all state updates on rising edge
//   clr       in   asynchronous active-high reset
//   in_valid  in   request present
//   in_ready  out  block is IDLE and can accept a request
//   in_data   in   [N-1:0] operand
//   in_amt    in   [AW-1:0] shift distance
//   in_dir    in   0 = right (toward LSB), 1 = left (toward MSB)
//   in_rot    in   rotate select
//   abort     in   synchronous cancel of the current operation
//   out_valid out  result present (state DONE)
//   out_ready in   consumer takes the result
//   out_data  out  [N-1:0] data register
//   busy      out  state is not IDLE

module shift_seq #(
  parameter int N  = 32,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  input  logic          in_dir,
  input  logic          in_rot,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_data;
  logic [AW-1:0] r_cnt;
  logic          r_dir;
  logic          r_rot;

  logic          w_accept;
  logic          w_rot_eff;
  logic          w_fill;
  logic [N-1:0]  w_step;

  // abort wins over in_valid, so an aborted IDLE cycle never accepts.
  assign w_accept = (r_state == IDLE) && in_valid && !abort;

`ifdef SHIFT_SEQ_ROT_EN
  assign w_rot_eff = r_rot;
`else
  // Rotate support compiled out: the mode bit is still captured so the
  // register map matches the rotate build, but it never reaches the datapath.
  logic w_unused_rot;
  assign w_rot_eff    = 1'b0;
  assign w_unused_rot = r_rot;
`endif

  // One step: the bit leaving the word re-enters at the vacated end when
  // rotating, otherwise the vacated end is zero-filled.
  always_comb begin
    w_fill = 1'b0;
    w_step = r_data;
    if (w_rot_eff) begin
      w_fill = r_dir ? r_data[N-1] : r_data[0];
    end
    if (r_dir) begin
      w_step = {r_data[N-2:0], w_fill};
    end else begin
      w_step = {w_fill, r_data[N-1:1]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == AW'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_rot   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data <= in_data;
        r_cnt  <= in_amt;
        r_dir  <= in_dir;
        r_rot  <= in_rot;
      end else if ((r_state == SHIFT) && !abort) begin
        r_data <= w_step;
        r_cnt  <= r_cnt - AW'(1);
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_data;

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - directed table-driven bench for shift_seq

module tb_shift_seq;

  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [AW-1:0] in_amt;
  logic          in_dir;
  logic          in_rot;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  shift_seq #(.N(N)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .in_rot    (in_rot),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  data;
    logic [AW-1:0] amt;
    logic          dir;
    logic          rot;
    logic [N-1:0]  exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept a request on the next rising edge; returns at the negedge after it.
  task automatic accept(input logic [N-1:0] d, input logic [AW-1:0] a,
                        input logic dr, input logic rt);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dr; in_rot = rt;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cycles;
    int busy_low;
    accept(v.data, v.amt, v.dir, v.rot);
    cycles = 0;
    busy_low = 0;
    while (!out_valid && cycles < 100) begin
      if (!busy) busy_low++;
      @(negedge clk);
      cycles++;
    end
    chk($sformatf("latency_v%0d", idx), 32'(cycles), 32'(v.amt));
    chk($sformatf("busy_low_v%0d", idx), 32'(busy_low), 32'd0);
    chk($sformatf("out_data_v%0d", idx), out_data, v.exp_data);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("idle_after_v%0d", idx), {30'd0, in_ready, out_valid}, 32'h2);
  endtask

  initial begin
    int seen;
    clr = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_dir = 1'b0;
    in_rot = 1'b0; abort = 1'b0; out_ready = 1'b0;

    vecs[0] = '{32'h0000_0001, 5'd4,  1'b1, 1'b0, 32'h0000_0010};
    vecs[1] = '{32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001};
    vecs[2] = '{32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[3] = '{32'hDEAD_BEEF, 5'd4,  1'b0, 1'b0, 32'h0DEA_DBEE};
    vecs[4] = '{32'hDEAD_BEEF, 5'd8,  1'b1, 1'b0, 32'hADBE_EF00};
    vecs[5] = '{32'hF000_0000, 5'd3,  1'b1, 1'b1, 32'h8000_0000};
`ifdef SHIFT_SEQ_ROT_EN
    vecs[5].exp_data = 32'h8000_0007;
    vecs[6] = '{32'h8000_0001, 5'd1,  1'b1, 1'b1, 32'h0000_0003};
    vecs[7] = '{32'h8000_0001, 5'd1,  1'b0, 1'b1, 32'hC000_0000};
    vecs[8] = '{32'h0000_000F, 5'd2,  1'b0, 1'b1, 32'hC000_0003};
`else
    vecs[6] = '{32'h8000_0001, 5'd1,  1'b1, 1'b1, 32'h0000_0002};
    vecs[7] = '{32'h8000_0001, 5'd1,  1'b0, 1'b1, 32'h4000_0000};
    vecs[8] = '{32'h0000_000F, 5'd2,  1'b0, 1'b1, 32'h0000_0003};
`endif

    // Reset state, during and after clr.
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    clr = 1'b0;
    @(negedge clk);
    chk("post_rst_state", {29'd0, in_ready, out_valid, busy}, 32'h4);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Backpressure in DONE with a competing request held on in_valid.
    accept(32'h0000_0001, 5'd2, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("stall_reached_done", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_amt = 5'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_flags_%0d", i), {30'd0, out_valid, in_ready}, 32'h2);
      chk($sformatf("stall_data_%0d", i), out_data, 32'h0000_0004);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_release_idle", {30'd0, in_ready, out_valid}, 32'h2);
    chk("stall_no_second_accept", out_data, 32'h0000_0004);

    // Abort two edges into a 10-step shift.
    accept(32'h0000_0001, 5'd10, 1'b1, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("abort_no_out_valid", 32'(seen), 32'd0);

    // abort beats in_valid in IDLE.
    in_valid = 1'b1; abort = 1'b1; in_amt = 5'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_blocks_accept", 32'(busy), 32'd0);

    // abort beats out_ready in DONE: result discarded, back to IDLE.
    accept(32'h1234_5678, 5'd0, 1'b0, 1'b0);
    chk("abort_done_valid", 32'(out_valid), 32'd1);
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    chk("abort_done_idle", {30'd0, in_ready, out_valid}, 32'h2);

    // clr mid-shift takes effect immediately, not at the next edge.
    accept(32'hA5A5_A5A5, 5'd10, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    chk("clr_out_data", out_data, 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("clr_no_out_valid", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
